// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
//
// Two-master arbiter in front of a single-port data memory with a registered
// read port (read data appears one cycle after the access).
//   port 0 (m0_*) : core data port. core_stall flags a request that was not
//                   granted this cycle.
//   port 1 (m1_*) : debug/loader port. m1_lock can claim the memory for up to
//                   LOCK_MAX consecutive grants.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   m0_req/we/addr/wdata       core request
//   m0_gnt/rvalid/rdata        core grant and read return
//   m1_req/we/lock/addr/wdata  debug/loader request
//   m1_gnt/rvalid/rdata        debug/loader grant and read return
//   mem_en/we/addr/wdata       memory access, issued in the grant cycle
//   mem_rdata                  memory read data, valid the cycle after a read
//   core_stall                 m0_req high while m0_gnt is low
//
// Arbitration is round-robin through a one-bit priority register: after any
// granted cycle priority passes to the other port; idle cycles leave it alone.
// A lone requester is always granted at once. A locked m1 grant moves the FSM
// to LOCKED, where m1 is served exclusively until it drops lock/req or the
// lock counter would pass LOCK_MAX. In that release cycle normal arbitration
// runs with m0 given first pick, which bounds the core's wait to LOCK_MAX.
// -----------------------------------------------------------------------------
module data_mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LOCK_MAX   = 8
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,

    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic                  m1_lock,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,

    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,

    output logic                  core_stall
);

    localparam int CNT_WIDTH = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_WIDTH-1:0] LOCK_LIMIT = CNT_WIDTH'(LOCK_MAX);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

    typedef enum logic {
        OPEN   = 1'b0,
        LOCKED = 1'b1
    } arbState_t;

    arbState_t             stateReg, stateNext;
    logic                  prioReg, prioNext;
    logic [CNT_WIDTH-1:0]  lockCntReg, lockCntNext;
    logic                  gnt0, gnt1;
    logic                  m1First;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg   <= OPEN;
            prioReg    <= 1'b0;
            lockCntReg <= '0;
        end else begin
            stateReg   <= stateNext;
            prioReg    <= prioNext;
            lockCntReg <= lockCntNext;
        end
    end

    // -------------------------------------------------------------------------
    // Grant decision and next state
    // -------------------------------------------------------------------------
    always_comb begin
        stateNext   = stateReg;
        prioNext    = prioReg;
        lockCntNext = lockCntReg;
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        m1First     = prioReg;

        if (reset) begin
            // No grants while in reset; the state register reloads itself.
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end else if (stateReg == LOCKED && m1_req && m1_lock &&
                     lockCntReg < LOCK_LIMIT) begin
            // Exclusive locked access with budget remaining.
            gnt1        = 1'b1;
            lockCntNext = lockCntReg + CNT_ONE;
        end else begin
            // Open arbitration. Coming out of a lock m0 gets the tie so the
            // core cannot be starved by back-to-back locks.
            m1First = (stateReg == LOCKED) ? 1'b0 : prioReg;
            if (m0_req && m1_req) begin
                gnt0 = ~m1First;
                gnt1 = m1First;
            end else begin
                gnt0 = m0_req;
                gnt1 = m1_req;
            end

            if (gnt1 && m1_lock) begin
                stateNext   = LOCKED;
                lockCntNext = CNT_ONE;
            end else begin
                stateNext   = OPEN;
                lockCntNext = '0;
            end
        end

        // Priority goes to the port that did not win (gnt0 -> m1 next).
        if (gnt0 || gnt1) begin
            prioNext = gnt0;
        end
    end

    // -------------------------------------------------------------------------
    // Memory side: issued in the grant cycle, zeros when idle
    // -------------------------------------------------------------------------
    always_comb begin
        mem_en    = gnt0 | gnt1;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt0) begin
            mem_we    = m0_we;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
        end else if (gnt1) begin
            mem_we    = m1_we;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end
    end

    assign m0_gnt     = gnt0;
    assign m1_gnt     = gnt1;
    assign core_stall = m0_req & ~gnt0 & ~reset;

    // -------------------------------------------------------------------------
    // Read return, one copy per port. The pending flag marks a read issued
    // last cycle; rdata follows mem_rdata in the return cycle and otherwise
    // shows the last value returned to that port.
    // -------------------------------------------------------------------------
    logic [1:0]            gntVec;
    logic [1:0]            weVec;
    logic [1:0]            rvalidVec;
    logic [DATA_WIDTH-1:0] rdataVec [2];

    assign gntVec = {gnt1, gnt0};
    assign weVec  = {m1_we, m0_we};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_readReturn
            logic                  rdPendReg;
            logic [DATA_WIDTH-1:0] rdataHoldReg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    rdPendReg    <= 1'b0;
                    rdataHoldReg <= '0;
                end else begin
                    rdPendReg <= gntVec[gi] & ~weVec[gi];
                    if (rdPendReg) begin
                        rdataHoldReg <= mem_rdata;
                    end
                end
            end

            // A read in flight when reset arrives is dropped, not delivered.
            assign rvalidVec[gi] = rdPendReg & ~reset;
            assign rdataVec[gi]  = rvalidVec[gi] ? mem_rdata : rdataHoldReg;
        end
    endgenerate

    assign m0_rvalid = rvalidVec[0];
    assign m1_rvalid = rvalidVec[1];
    assign m0_rdata  = rdataVec[0];
    assign m1_rdata  = rdataVec[1];

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the data bus width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, the address bus width.
REQ-003 SHALL have parameter LOCK_MAX, default 8, the maximum consecutive locked grants to port 1.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, a synchronous, active-high reset.
REQ-006 SHALL have ports m0_req, m0_we, input, 1 each: core data-port request and write strobe.
REQ-007 SHALL have ports m0_addr (ADDR_WIDTH) and m0_wdata (DATA_WIDTH), input: core address and write data.
REQ-008 SHALL have ports m0_gnt and m0_rvalid, output, 1 each: core grant and read-data-valid.
REQ-009 SHALL have port m0_rdata, output, DATA_WIDTH: core read data.
REQ-010 SHALL have ports m1_req, m1_we, m1_lock, input, 1 each: debug/loader request, write strobe and lock.
REQ-011 SHALL have ports m1_addr and m1_wdata, input, with the same widths as the port-0 equivalents.
REQ-012 SHALL have ports m1_gnt, m1_rvalid (output, 1) and m1_rdata (output, DATA_WIDTH).
REQ-013 SHALL have ports mem_en and mem_we, output, 1 each: single-port memory enable and write.
REQ-014 SHALL have ports mem_addr (ADDR_WIDTH) and mem_wdata (DATA_WIDTH), output, to the memory.
REQ-015 SHALL have port mem_rdata, input, DATA_WIDTH: memory read data, valid one cycle after a read access.
REQ-016 SHALL have port core_stall, output, 1: high while m0_req is asserted and m0_gnt is low.

Function
REQ-017 SHALL grant at most one port per cycle: gnt is combinational from the req inputs and registered state, and the access is issued to memory in the same cycle.
REQ-018 SHALL drive mem_en as m0_gnt OR m1_gnt, and drive mem_we/mem_addr/mem_wdata from the granted port; with no grant, all memory outputs SHALL be 0.
REQ-019 SHALL arbitrate round-robin using a registered priority bit prio, where 0 means m0 wins a tie.
REQ-020 SHALL set prio to the opposite of the granted port after every granted cycle and SHALL leave it unchanged on idle cycles.
REQ-021 SHALL grant a single requester immediately, regardless of prio.
REQ-022 SHALL implement a 2-state FSM with states OPEN and LOCKED.
REQ-023 (OPEN -> LOCKED) SHALL move to LOCKED when m1 is granted with m1_lock=1, and SHALL load lock_cnt=1.
REQ-024 (LOCKED) SHALL grant m1 exclusively while m1_req=1 and m1_lock=1, and SHALL increment lock_cnt (ceil(log2(LOCK_MAX+1)) bits) on each granted cycle.
REQ-025 (LOCKED -> OPEN) SHALL return to OPEN when m1_lock=0, when m1_req=0, or when a grant would make lock_cnt exceed LOCK_MAX; in that cycle arbitration SHALL be OPEN rules with prio forced to 0, so m0 wins a tie.
REQ-026 SHALL register pending-read flags rd0/rd1 when a granted access has we=0; in the following cycle mX_rvalid=1 and mX_rdata=mem_rdata, otherwise rvalid=0 and rdata holds its last value.
REQ-027 SHALL NOT assert rvalid for a write access.
REQ-028 (back-to-back) SHALL allow a new grant in the cycle that delivers rvalid for the previous read, giving a throughput of one access per cycle.
REQ-029 (simultaneous writes from both ports) SHALL perform only the granted write; the losing port SHALL hold its request and be served next by rotation.
REQ-030 (request deasserted while waiting) SHALL cause no access and leave no state change for the dropped port.
REQ-031 (starvation bound) SHALL guarantee m0 waits at most LOCK_MAX cycles.

Reset
REQ-032 SHALL, while reset=1, at the clock edge set the FSM to OPEN and set prio=0, lock_cnt=0, rd0=rd1=0 and m0_rdata=m1_rdata=0.
REQ-033 SHALL force all gnt outputs, mem_en, mem_we and core_stall low during a reset cycle.
REQ-034 (reset mid-lock or with a read pending) SHALL discard the pending rvalid and SHALL leave the lock released after reset.

Verification
REQ-035 SHALL verify solo read: m0 reads address 0x10 with mem content 0xDEADBEEF -> m0_gnt in the same cycle, and m0_rvalid=1 with m0_rdata=0xDEADBEEF in the next cycle.
REQ-036 SHALL verify contention: both ports request reads for 4 cycles from reset -> grants m0, m1, m0, m1, with core_stall high in cycles 2 and 4.
REQ-037 SHALL verify lock limit: m1_lock=1 and m1_req=1 held for 12 cycles with m0_req=1 and LOCK_MAX=8 -> m1 granted in cycles 1-8, m0 granted in cycle 9, core_stall high in cycles 1-8.
REQ-038 SHALL verify simultaneous writes: m0 writes 0x11 to 0x4 and m1 writes 0x22 to 0x4 in the same cycle with prio=0 -> memory holds 0x11 after cycle 1 and 0x22 after cycle 2, with no rvalid in either cycle.
REQ-039 SHALL verify reset mid-lock: reset asserted in cycle 3 of an m1 lock while an m1 read is pending -> m1_rvalid=0, FSM OPEN and prio=0 on the next cycle, and m0 alone requesting is granted immediately after reset drops.
